// File: rtl/frame_checker_p.sv
// frame_checker_p
//   Checks frames of FRAME_LEN words from the RAM read path against an
//   arithmetic reference sequence (SEED, SEED+STEP, ...). The sequence runs on
//   across frames and is never rewound except by reset. Words are consumed
//   only when i_data_valid is high; gaps are tolerated up to TIMEOUT idle
//   cycles (0 disables the timeout).
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           pulse: begin a new frame (aborts one in progress)
//   i_data_valid      i_data carries a word this cycle
//   i_data            received word
//   o_busy            frame in progress
//   o_checking_done   1-cycle pulse at end of frame (normal or timeout)
//   o_valid_frame     with done: no mismatches and no timeout
//   o_timeout         with done: frame ended by inactivity
//   o_err_count       saturating mismatch count of the last/current frame
//   o_first_err_idx   word index of the first mismatch, all-ones if none
//   o_first_err_data  received word at the first mismatch, 0 if none
//   o_frames_ok       saturating count of passing frames
//   o_frames_bad      saturating count of failing or timed-out frames
module frame_checker_p #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       FRAME_LEN = 64,
   parameter logic [DATA_W-1:0] SEED      = '0,
   parameter logic [DATA_W-1:0] STEP      = DATA_W'(1),
   parameter int unsigned       ERR_CNT_W = 8,
   parameter int unsigned       TIMEOUT   = 256,
   parameter int unsigned       FRM_CNT_W = 16,
   localparam int unsigned      IDX_W     = $clog2(FRAME_LEN) + 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_data_valid,
   input  logic [DATA_W-1:0]    i_data,
   output logic                 o_busy,
   output logic                 o_checking_done,
   output logic                 o_valid_frame,
   output logic                 o_timeout,
   output logic [ERR_CNT_W-1:0] o_err_count,
   output logic [IDX_W-1:0]     o_first_err_idx,
   output logic [DATA_W-1:0]    o_first_err_data,
   output logic [FRM_CNT_W-1:0] o_frames_ok,
   output logic [FRM_CNT_W-1:0] o_frames_bad
);

   localparam int unsigned   IDLE_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

   state_t                 state, state_nxt;
   logic [DATA_W-1:0]      expected, expected_nxt;
   logic [IDX_W-1:0]       word_cnt, word_cnt_nxt;
   logic [ERR_CNT_W-1:0]   err_count, err_count_nxt;
   logic [IDX_W-1:0]       first_idx, first_idx_nxt;
   logic [DATA_W-1:0]      first_data, first_data_nxt;
   logic [IDLE_W-1:0]      idle_cnt, idle_cnt_nxt;
   logic                   timed_out, timed_out_nxt;
   logic [FRM_CNT_W-1:0]   frames_ok, frames_ok_nxt;
   logic [FRM_CNT_W-1:0]   frames_bad, frames_bad_nxt;
   logic                   last_word;
   logic                   frame_end;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         expected   <= SEED;
         word_cnt   <= '0;
         err_count  <= '0;
         first_idx  <= '1;
         first_data <= '0;
         idle_cnt   <= '0;
         timed_out  <= 1'b0;
         frames_ok  <= '0;
         frames_bad <= '0;
      end else begin
         state      <= state_nxt;
         expected   <= expected_nxt;
         word_cnt   <= word_cnt_nxt;
         err_count  <= err_count_nxt;
         first_idx  <= first_idx_nxt;
         first_data <= first_data_nxt;
         idle_cnt   <= idle_cnt_nxt;
         timed_out  <= timed_out_nxt;
         frames_ok  <= frames_ok_nxt;
         frames_bad <= frames_bad_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      expected_nxt   = expected;
      word_cnt_nxt   = word_cnt;
      err_count_nxt  = err_count;
      first_idx_nxt  = first_idx;
      first_data_nxt = first_data;
      idle_cnt_nxt   = idle_cnt;
      timed_out_nxt  = timed_out;
      frames_ok_nxt  = frames_ok;
      frames_bad_nxt = frames_bad;
      last_word      = 1'b0;
      frame_end      = 1'b0;

      // i_start opens a fresh frame from any state. The cleared values act as
      // the base for CHECK below, so a word arriving together with a restart
      // is counted as word 0 of the new frame.
      if (i_start) begin
         state_nxt      = CHECK;
         word_cnt_nxt   = '0;
         err_count_nxt  = '0;
         first_idx_nxt  = '1;
         first_data_nxt = '0;
         idle_cnt_nxt   = '0;
         timed_out_nxt  = 1'b0;
      end

      case (state)
         IDLE: ;
         CHECK: begin
            if (i_data_valid) begin
               last_word    = (word_cnt_nxt == LAST_IDX);
               idle_cnt_nxt = '0;
               expected_nxt = expected + STEP;
               if (i_data != expected) begin
                  if (err_count_nxt != '1)
                     err_count_nxt = err_count_nxt + ERR_CNT_W'(1);
                  // first_idx can never legitimately be all-ones, so it doubles
                  // as the "no mismatch yet" marker
                  if (first_idx_nxt == '1) begin
                     first_idx_nxt  = word_cnt_nxt;
                     first_data_nxt = i_data;
                  end
               end
               word_cnt_nxt = word_cnt_nxt + IDX_W'(1);
               frame_end    = last_word;
            end else if (TIMEOUT != 0) begin
               idle_cnt_nxt = idle_cnt_nxt + IDLE_W'(1);
               if (idle_cnt_nxt == TIMEOUT_V) begin
                  timed_out_nxt = 1'b1;
                  frame_end     = 1'b1;
               end
            end
            // tallies are updated on the way into DONE so they already show
            // the new result while the done pulse is high
            if (frame_end) begin
               state_nxt = DONE;
               if (err_count_nxt == '0 && !timed_out_nxt) begin
                  if (frames_ok != '1) frames_ok_nxt = frames_ok + FRM_CNT_W'(1);
               end else begin
                  if (frames_bad != '1) frames_bad_nxt = frames_bad + FRM_CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (!i_start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_busy           = (state == CHECK);
   assign o_checking_done  = (state == DONE);
   assign o_valid_frame    = (state == DONE) && (err_count == '0) && !timed_out;
   assign o_timeout        = (state == DONE) && timed_out;
   assign o_err_count      = err_count;
   assign o_first_err_idx  = first_idx;
   assign o_first_err_data = first_data;
   assign o_frames_ok      = frames_ok;
   assign o_frames_bad     = frames_bad;

endmodule

// File: tb/tb_frame_checker_p.sv
// tb_frame_checker_p
//   Three checker instances share one clock and reset:
//     u0  defaults (64 words, STEP 1, 8-bit error count, timeout 256)
//     u1  STEP all-ones (descending wrap) and a 4-bit error count
//     u2  single-word frames, SEED 0x1000, STEP 5, timeout 3
//   Each frame's expected result is computed from the words actually sent
//   and the reference sequence position kept by the bench.
module tb_frame_checker_p;

   localparam int NDUT = 3;

   typedef logic [31:0] wq_t[$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start_s [NDUT];
   logic        valid_s [NDUT];
   logic [31:0] data_s  [NDUT];

   logic        busy_o  [NDUT];
   logic        done_o  [NDUT];
   logic        vf_o    [NDUT];
   logic        to_o    [NDUT];
   logic [31:0] fdata_o [NDUT];
   logic [31:0] errc_o  [NDUT];
   logic [31:0] fidx_o  [NDUT];
   logic [31:0] ok_o    [NDUT];
   logic [31:0] bad_o   [NDUT];

   logic [7:0]  e0, e2;
   logic [3:0]  e1;
   logic [6:0]  x0, x1;
   logic [0:0]  x2;
   logic [15:0] ok0, ok1, ok2, bad0, bad1, bad2;

   assign errc_o[0] = 32'(e0);
   assign errc_o[1] = 32'(e1);
   assign errc_o[2] = 32'(e2);
   assign fidx_o[0] = 32'(x0);
   assign fidx_o[1] = 32'(x1);
   assign fidx_o[2] = 32'(x2);
   assign ok_o[0]   = 32'(ok0);
   assign ok_o[1]   = 32'(ok1);
   assign ok_o[2]   = 32'(ok2);
   assign bad_o[0]  = 32'(bad0);
   assign bad_o[1]  = 32'(bad1);
   assign bad_o[2]  = 32'(bad2);

   frame_checker_p #(.DATA_W(32), .FRAME_LEN(64), .SEED(32'h0), .STEP(32'h1),
                     .ERR_CNT_W(8), .TIMEOUT(256), .FRM_CNT_W(16)) u0 (
      .i_clk(clk), .i_rst(rst), .i_start(start_s[0]), .i_data_valid(valid_s[0]),
      .i_data(data_s[0]), .o_busy(busy_o[0]), .o_checking_done(done_o[0]),
      .o_valid_frame(vf_o[0]), .o_timeout(to_o[0]), .o_err_count(e0),
      .o_first_err_idx(x0), .o_first_err_data(fdata_o[0]),
      .o_frames_ok(ok0), .o_frames_bad(bad0));

   frame_checker_p #(.DATA_W(32), .FRAME_LEN(64), .SEED(32'h0), .STEP(32'hFFFF_FFFF),
                     .ERR_CNT_W(4), .TIMEOUT(256), .FRM_CNT_W(16)) u1 (
      .i_clk(clk), .i_rst(rst), .i_start(start_s[1]), .i_data_valid(valid_s[1]),
      .i_data(data_s[1]), .o_busy(busy_o[1]), .o_checking_done(done_o[1]),
      .o_valid_frame(vf_o[1]), .o_timeout(to_o[1]), .o_err_count(e1),
      .o_first_err_idx(x1), .o_first_err_data(fdata_o[1]),
      .o_frames_ok(ok1), .o_frames_bad(bad1));

   frame_checker_p #(.DATA_W(32), .FRAME_LEN(1), .SEED(32'h1000), .STEP(32'h5),
                     .ERR_CNT_W(8), .TIMEOUT(3), .FRM_CNT_W(16)) u2 (
      .i_clk(clk), .i_rst(rst), .i_start(start_s[2]), .i_data_valid(valid_s[2]),
      .i_data(data_s[2]), .o_busy(busy_o[2]), .o_checking_done(done_o[2]),
      .o_valid_frame(vf_o[2]), .o_timeout(to_o[2]), .o_err_count(e2),
      .o_first_err_idx(x2), .o_first_err_data(fdata_o[2]),
      .o_frames_ok(ok2), .o_frames_bad(bad2));

   // per-instance configuration
   function automatic int fl(input int k);
      return (k == 2) ? 1 : 64;
   endfunction
   function automatic logic [31:0] stepv(input int k);
      case (k)
         1:       return 32'hFFFF_FFFF;
         2:       return 32'd5;
         default: return 32'd1;
      endcase
   endfunction
   function automatic logic [31:0] seedv(input int k);
      return (k == 2) ? 32'h1000 : 32'h0;
   endfunction
   function automatic int errmax(input int k);
      return (k == 1) ? 15 : 255;
   endfunction
   function automatic int tmo_cycles(input int k);
      return (k == 2) ? 3 : 256;
   endfunction
   function automatic int idxmax(input int k);
      return (1 << ($clog2(fl(k)) + 1)) - 1;
   endfunction

   // reference model state: next expected word and frame tallies
   logic [31:0] m_exp [NDUT];
   int          m_ok  [NDUT];
   int          m_bad [NDUT];

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic string tg(input int k, input string s);
      return $sformatf("u%0d_%s", k, s);
   endfunction

   function automatic wq_t good_words(input int k, input int n);
      wq_t q;
      logic [31:0] v;
      v = m_exp[k];
      for (int i = 0; i < n; i++) begin
         q.push_back(v);
         v = v + stepv(k);
      end
      return q;
   endfunction

   // mode: 0 = separate start pulse, 1 = start together with word 0,
   //       2 = start already issued during the previous DONE cycle
   task automatic run_frame(input int k, input wq_t w, input int gmin, input int gmax,
                            input int mode, input bit chain, input bit tmo);
      int          n, errs, fi;
      logic [31:0] fd, r;
      bit          pass, odd;
      n    = w.size();
      errs = 0;
      fi   = idxmax(k);
      fd   = 32'h0;
      odd  = 1'b0;
      r    = m_exp[k];
      for (int i = 0; i < n; i++) begin
         if (w[i] != r) begin
            if (errs == 0) begin
               fi = i;
               fd = w[i];
            end
            errs++;
         end
         r = r + stepv(k);
      end
      pass = (errs == 0) && !tmo;
      if (errs > errmax(k)) errs = errmax(k);
      m_exp[k] = r;
      if (pass) m_ok[k]++;
      else      m_bad[k]++;

      if (mode == 0) begin
         @(negedge clk);
         start_s[k] = 1'b1; valid_s[k] = 1'b0; data_s[k] = $urandom;
      end
      for (int i = 0; i < n; i++) begin
         if (!(mode == 1 && i == 0)) begin
            repeat ($urandom_range(gmax, gmin)) begin
               @(negedge clk);
               if (done_o[k] || !busy_o[k]) odd = 1'b1;
               start_s[k] = 1'b0; valid_s[k] = 1'b0; data_s[k] = $urandom;
            end
         end
         @(negedge clk);
         if (done_o[k] || !busy_o[k]) odd = 1'b1;
         start_s[k] = (mode == 1 && i == 0); valid_s[k] = 1'b1; data_s[k] = w[i];
      end
      if (tmo) begin
         repeat (tmo_cycles(k)) begin
            @(negedge clk);
            if (done_o[k] || !busy_o[k]) odd = 1'b1;
            start_s[k] = 1'b0; valid_s[k] = 1'b0; data_s[k] = $urandom;
         end
      end

      @(negedge clk);
      check_eq(tg(k, "frame_busy_no_early_done"), 32'(odd), 32'h0);
      check_eq(tg(k, "done"), 32'(done_o[k]), 32'h1);
      check_eq(tg(k, "busy_in_done"), 32'(busy_o[k]), 32'h0);
      check_eq(tg(k, "valid_frame"), 32'(vf_o[k]), 32'(pass));
      check_eq(tg(k, "timeout"), 32'(to_o[k]), 32'(tmo));
      check_eq(tg(k, "err_count"), errc_o[k], errs);
      check_eq(tg(k, "first_err_idx"), fidx_o[k], fi);
      check_eq(tg(k, "first_err_data"), fdata_o[k], fd);
      check_eq(tg(k, "frames_ok"), ok_o[k], m_ok[k]);
      check_eq(tg(k, "frames_bad"), bad_o[k], m_bad[k]);

      // data offered during DONE must be ignored
      start_s[k] = chain; valid_s[k] = 1'($urandom_range(1, 0)); data_s[k] = $urandom;
      if (!chain) begin
         @(negedge clk);
         check_eq(tg(k, "done_busy_after"), {30'h0, done_o[k], busy_o[k]}, 32'h0);
         check_eq(tg(k, "err_count_hold"), errc_o[k], errs);
         check_eq(tg(k, "first_err_idx_hold"), fidx_o[k], fi);
         valid_s[k] = 1'b0;
      end
   endtask

   // starts a frame and feeds n correct words without finishing it
   task automatic run_partial(input int k, input int n);
      bit odd;
      odd = 1'b0;
      @(negedge clk);
      start_s[k] = 1'b1; valid_s[k] = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done_o[k] || !busy_o[k]) odd = 1'b1;
         start_s[k] = 1'b0; valid_s[k] = 1'b1; data_s[k] = m_exp[k];
         m_exp[k] = m_exp[k] + stepv(k);
      end
      @(negedge clk);
      if (done_o[k] || !busy_o[k]) odd = 1'b1;
      valid_s[k] = 1'b0;
      check_eq(tg(k, "partial_no_done"), 32'(odd), 32'h0);
   endtask

   initial begin
      wq_t q;
      bit  ch, chained;

      rst = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
         start_s[k] = 1'b0; valid_s[k] = 1'b0; data_s[k] = 32'h0;
         m_exp[k] = seedv(k); m_ok[k] = 0; m_bad[k] = 0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check_eq(tg(k, "rst_flags"), {28'h0, busy_o[k], done_o[k], vf_o[k], to_o[k]}, 32'h0);
         check_eq(tg(k, "rst_err_count"), errc_o[k], 32'h0);
         check_eq(tg(k, "rst_first_err_idx"), fidx_o[k], idxmax(k));
         check_eq(tg(k, "rst_first_err_data"), fdata_o[k], 32'h0);
         check_eq(tg(k, "rst_tallies"), ok_o[k] | bad_o[k], 32'h0);
      end
      rst = 1'b0;

      // u0: back-to-back pass, gapped pass, stale sequence fail, two corruptions
      q = good_words(0, 64);
      run_frame(0, q, 0, 0, 0, 1'b0, 1'b0);
      q = good_words(0, 64);
      run_frame(0, q, 3, 3, 0, 1'b0, 1'b0);
      q.delete();
      for (int i = 0; i < 64; i++) q.push_back(32'(i));
      run_frame(0, q, 0, 0, 0, 1'b0, 1'b0);
      q = good_words(0, 64);
      q[10] = 32'hDEAD_BEEF;
      q[40] = q[40] ^ (32'h1 << $urandom_range(31, 0));
      run_frame(0, q, 0, 2, 0, 1'b0, 1'b0);

      // u0: random corruption and gaps, some frames restarted from DONE
      chained = 1'b0;
      for (int j = 0; j < 8; j++) begin
         q = good_words(0, 64);
         for (int i = 0; i < 64; i++)
            if ($urandom_range(15, 0) == 0) q[i] = q[i] ^ (32'h1 << $urandom_range(31, 0));
         ch = (j < 7) && ($urandom_range(1, 0) == 1);
         run_frame(0, q, 0, 4, chained ? 2 : 0, ch, 1'b0);
         chained = ch;
      end

      // u0: 20 words then silence
      q = good_words(0, 20);
      run_frame(0, q, 0, 0, 0, 1'b0, 1'b1);

      // u0: restart after 30 words; word 0 of the new frame rides on i_start
      run_partial(0, 30);
      q = good_words(0, 64);
      run_frame(0, q, 0, 1, 1, 1'b0, 1'b0);

      // u1: descending wrap sequence, then all wrong (count saturates), then pass
      q = good_words(1, 64);
      run_frame(1, q, 0, 1, 0, 1'b0, 1'b0);
      q = good_words(1, 64);
      for (int i = 0; i < 64; i++) q[i] = q[i] ^ 32'h8000_0000;
      run_frame(1, q, 0, 0, 0, 1'b0, 1'b0);
      q = good_words(1, 64);
      run_frame(1, q, 0, 0, 0, 1'b0, 1'b0);

      // u2: single-word frames, then a timeout with no words, then a pass
      chained = 1'b0;
      for (int j = 0; j < 8; j++) begin
         q = good_words(2, 1);
         if ($urandom_range(1, 0) == 1) q[0] = ~q[0];
         ch = (j < 7) && ($urandom_range(1, 0) == 1);
         run_frame(2, q, 0, 2, chained ? 2 : 0, ch, 1'b0);
         chained = ch;
      end
      q.delete();
      run_frame(2, q, 0, 0, 0, 1'b0, 1'b1);
      q = good_words(2, 1);
      run_frame(2, q, 0, 2, 0, 1'b0, 1'b0);

      // reset in the middle of a frame: no done, everything back to start
      @(negedge clk);
      start_s[0] = 1'b1; valid_s[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start_s[0] = 1'b0; valid_s[0] = 1'b1; data_s[0] = m_exp[0] + 32'(i);
      end
      @(negedge clk);
      rst = 1'b1; valid_s[0] = 1'b0;
      @(negedge clk);
      check_eq("u0_midrst_flags", {30'h0, busy_o[0], done_o[0]}, 32'h0);
      check_eq("u0_midrst_err_count", errc_o[0], 32'h0);
      check_eq("u0_midrst_first_err_idx", fidx_o[0], idxmax(0));
      check_eq("u0_midrst_tallies", ok_o[0] | bad_o[0], 32'h0);
      rst = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         m_exp[k] = seedv(k); m_ok[k] = 0; m_bad[k] = 0;
      end
      q = good_words(0, 64);
      run_frame(0, q, 0, 1, 0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
